// File: rtl/dt_storage_bank.sv
// Bank of CHANNELS independent WIDTH-bit storage channels, each run as a D flop, T flop,
// transparent latch or synchronous clear, all sharing one write port.
module dt_storage_bank #(
  parameter int               WIDTH     = 8,
  parameter int               CHANNELS  = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               SELW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [SELW-1:0]              sel,
  input  logic [WIDTH-1:0]             d,
  input  logic [2*CHANNELS-1:0]        mode,
  output logic [WIDTH*CHANNELS-1:0]    q,
  output logic [WIDTH*CHANNELS-1:0]    q_bar,
  output logic [CHANNELS-1:0]          chg
);

  localparam logic [1:0] M_DFF   = 2'b00;
  localparam logic [1:0] M_TFF   = 2'b01;
  localparam logic [1:0] M_LATCH = 2'b10;
  localparam logic [1:0] M_CLR   = 2'b11;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [1:0]       m;
    logic             hit;
    logic             wr;
    logic             lat_open;
    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] ff_q, ff_d;
    logic [WIDTH-1:0] lat_q;
    logic             ft_q, ft_d;
    logic             lt_q;
    logic             chg_q, chg_d;

    assign m   = mode[2*c +: 2];
    assign hit = en && (int'(sel) == c);

    // Flop and latch each keep a copy; the parity bits ft/lt mark whichever was
    // written last: lt != ft means the latch holds the live value.
    assign cur = (lt_q != ft_q) ? lat_q : ff_q;

    always_comb begin
      nxt = cur;
      wr  = 1'b0;
      if (hit) begin
        case (m)
          M_DFF:   begin nxt = d;         wr = 1'b1; end
          M_TFF:   begin nxt = cur ^ d;   wr = 1'b1; end
          M_CLR:   begin nxt = RESET_VAL; wr = 1'b1; end
          default: begin nxt = cur;       wr = 1'b0; end
        endcase
      end
      ff_d  = wr ? nxt : ff_q;
      ft_d  = wr ? lt_q : ft_q;
      chg_d = wr && (nxt != cur);
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        ff_q  <= RESET_VAL;
        ft_q  <= 1'b0;
        chg_q <= 1'b0;
      end else begin
        ff_q  <= ff_d;
        ft_q  <= ft_d;
        chg_q <= chg_d;
      end
    end

    assign lat_open = clk && hit && (m == M_LATCH);

    always_latch begin
      if (rst) begin
        lat_q <= RESET_VAL;
        lt_q  <= 1'b0;
      end else if (lat_open) begin
        lat_q <= d;
        lt_q  <= ~ft_q;
      end
    end

    assign q[WIDTH*c +: WIDTH]     = cur;
    assign q_bar[WIDTH*c +: WIDTH] = ~cur;
    assign chg[c]                  = chg_q && (m != M_LATCH);
  end

endmodule

// File: tb/tb_dt_storage_bank.sv
// Directed bench for dt_storage_bank: flop-mode vector table plus hand-written latch
// and asynchronous reset sequences.
module tb_dt_storage_bank;

  logic        clk;
  logic        rst;
  logic        en;
  logic [1:0]  sel;
  logic [7:0]  d;
  logic [7:0]  mode;
  logic [31:0] q;
  logic [31:0] q_bar;
  logic [3:0]  chg;

  int n_pass;
  int n_total;

  dt_storage_bank #(
    .WIDTH(8), .CHANNELS(4), .RESET_VAL(8'hA5)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .sel(sel), .d(d), .mode(mode),
    .q(q), .q_bar(q_bar), .chg(chg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk_all(input string name, input logic [31:0] exp_q, input logic [3:0] exp_chg);
    chk({name, ".q"}, q, exp_q);
    chk({name, ".q_bar"}, q_bar, ~exp_q);
    chk({name, ".chg"}, {28'd0, chg}, {28'd0, exp_chg});
  endtask

  typedef struct {
    logic        en;
    logic [1:0]  sel;
    logic [7:0]  d;
    logic [7:0]  mode;
    logic [31:0] exp_q;
    logic [3:0]  exp_chg;
  } vec_t;

  vec_t vt[15];

  initial begin
    // mode = {m3, m2, m1, m0}
    vt[0]  = '{1'b1, 2'd0, 8'h3C, 8'b00_00_01_00, 32'hA5A5A53C, 4'b0001};
    vt[1]  = '{1'b0, 2'd0, 8'h00, 8'b00_00_01_00, 32'hA5A5A53C, 4'b0000};
    vt[2]  = '{1'b0, 2'd0, 8'hFF, 8'b00_00_01_00, 32'hA5A5A53C, 4'b0000};
    vt[3]  = '{1'b0, 2'd1, 8'h0F, 8'b00_00_01_00, 32'hA5A5A53C, 4'b0000};
    vt[4]  = '{1'b1, 2'd0, 8'h3C, 8'b00_00_01_00, 32'hA5A5A53C, 4'b0000};
    vt[5]  = '{1'b1, 2'd1, 8'h0F, 8'b00_00_01_00, 32'hA5A5AA3C, 4'b0010};
    vt[6]  = '{1'b1, 2'd1, 8'h0F, 8'b00_00_01_00, 32'hA5A5A53C, 4'b0010};
    vt[7]  = '{1'b1, 2'd1, 8'h00, 8'b00_00_01_00, 32'hA5A5A53C, 4'b0000};
    vt[8]  = '{1'b1, 2'd3, 8'hFF, 8'b00_00_01_00, 32'hFFA5A53C, 4'b1000};
    vt[9]  = '{1'b1, 2'd3, 8'h12, 8'b11_00_01_00, 32'hA5A5A53C, 4'b1000};
    vt[10] = '{1'b1, 2'd3, 8'h5A, 8'b00_00_01_00, 32'h5AA5A53C, 4'b1000};
    vt[11] = '{1'b1, 2'd0, 8'h77, 8'b11_00_01_00, 32'h5AA5A577, 4'b0001};
    vt[12] = '{1'b1, 2'd2, 8'hC3, 8'b11_00_01_00, 32'h5AC3A577, 4'b0100};
    vt[13] = '{1'b1, 2'd1, 8'h12, 8'b11_00_00_00, 32'h5AC31277, 4'b0010};
    vt[14] = '{1'b0, 2'd3, 8'h00, 8'b11_00_00_00, 32'h5AC31277, 4'b0000};

    n_pass = 0;
    n_total = 0;
    rst = 1'b1; en = 1'b0; sel = 2'd0; d = 8'h00; mode = 8'h00;
    #1;
    chk_all("reset", 32'hA5A5A5A5, 4'b0000);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      en = vt[i].en; sel = vt[i].sel; d = vt[i].d; mode = vt[i].mode;
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), vt[i].exp_q, vt[i].exp_chg);
    end

    // Channel 2 as transparent latch
    @(negedge clk);
    mode = 8'b00_10_00_00; en = 1'b1; sel = 2'd2; d = 8'h11;
    @(posedge clk);
    #1;
    chk("latch_11", {24'd0, q[23:16]}, 32'h11);
    d = 8'h22;
    #1;
    chk("latch_22", {24'd0, q[23:16]}, 32'h22);
    d = 8'h33;
    #1;
    chk("latch_33", {24'd0, q[23:16]}, 32'h33);
    chk_all("latch_open", 32'h5A331277, 4'b0000);
    @(negedge clk);
    #1;
    d = 8'h44;
    #1;
    chk("latch_hold", {24'd0, q[23:16]}, 32'h33);
    en = 1'b0;
    @(posedge clk);
    #1;
    chk_all("latch_closed", 32'h5A331277, 4'b0000);

    // Reset while the latch is open
    @(negedge clk);
    en = 1'b1; d = 8'h55;
    @(posedge clk);
    #1;
    chk("latch_55", {24'd0, q[23:16]}, 32'h55);
    #1;
    rst = 1'b1;
    #1;
    chk("latch_rst", {24'd0, q[23:16]}, 32'hA5);
    chk_all("latch_rst_all", 32'hA5A5A5A5, 4'b0000);
    @(negedge clk);
    mode = 8'h00; sel = 2'd0; d = 8'h66;
    @(posedge clk);
    #1;
    chk_all("rst_hold_write", 32'hA5A5A5A5, 4'b0000);
    @(negedge clk);
    rst = 1'b0; en = 1'b0;

    // First edge after reset release operates normally; then async reset mid-cycle
    @(negedge clk);
    en = 1'b1; sel = 2'd0; d = 8'h99;
    @(posedge clk);
    #1;
    chk_all("post_rst_write", 32'hA5A5A599, 4'b0001);
    #1;
    rst = 1'b1;
    #1;
    chk_all("mid_cycle_rst", 32'hA5A5A5A5, 4'b0000);
    @(negedge clk);
    rst = 1'b0; en = 1'b0;

    // T flop from reset value with d = 0 holds
    @(negedge clk);
    mode = 8'b00_00_01_00; en = 1'b1; sel = 2'd1; d = 8'h00;
    @(posedge clk);
    #1;
    chk_all("tff_zero", 32'hA5A5A5A5, 4'b0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
